// File: rtl/kill_servo_ctrl.sv
// Pan/trigger hobby-servo sequencer for the kill action: aim, fire, return, done.
// Both 50 Hz PWM channels latch new pulse widths only on period boundaries, so no pulse is ever cut short.
module kill_servo_ctrl #(
  parameter int PERIOD_CYC   = 500000,
  parameter int PULSE_MIN    = 25000,
  parameter int PULSE_SPAN   = 25000,
  parameter int HOME_ANGLE   = 128,
  parameter int TRIG_REST    = 0,
  parameter int TRIG_FIRE    = 200,
  parameter int AIM_PERIODS  = 25,
  parameter int FIRE_PERIODS = 10,
  parameter int RET_PERIODS  = 25
) (
  input  logic       i_clk_25,
  input  logic       i_rst,
  input  logic       i_kill_req,
  input  logic [7:0] i_target_angle,
  input  logic       i_abort,
  output logic       o_pwm_pan,
  output logic       o_pwm_trig,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_state
);

  // state    | meaning
  // S_IDLE   | pan home, trigger rest, waiting for a kill request
  // S_AIM    | pan at target, trigger rest
  // S_FIRE   | pan at target, trigger pulled
  // S_RETURN | pan home, trigger rest, settling before completion
  // S_DONE   | single-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_FIRE   = 3'd2,
    S_RETURN = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int CW     = $clog2(PERIOD_CYC);
  localparam int WW     = 20;
  localparam int DW     = 16;
  localparam int AIM_N  = (AIM_PERIODS  < 1) ? 1 : AIM_PERIODS;
  localparam int FIRE_N = (FIRE_PERIODS < 1) ? 1 : FIRE_PERIODS;
  localparam int RET_N  = (RET_PERIODS  < 1) ? 1 : RET_PERIODS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD_CYC - 1);
  localparam logic [DW-1:0] AIM_LAST  = DW'(AIM_N - 1);
  localparam logic [DW-1:0] FIRE_LAST = DW'(FIRE_N - 1);
  localparam logic [DW-1:0] RET_LAST  = DW'(RET_N - 1);
  localparam logic [7:0]    HOME_A    = 8'(HOME_ANGLE);
  localparam logic [7:0]    REST_A    = 8'(TRIG_REST);
  localparam logic [7:0]    FIRE_A    = 8'(TRIG_FIRE);

  // Product kept 28 bits wide so full-scale spans never overflow before the >>8.
  function automatic logic [WW-1:0] pulse(input logic [7:0] angle);
    logic [27:0] prod;
    prod = 28'(angle) * 28'(PULSE_SPAN);
    return WW'(PULSE_MIN) + WW'(prod >> 8);
  endfunction

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dwell, dwell_nx;
  logic [7:0]    tgt, tgt_nx;
  logic [7:0]    pan_cmd, trig_cmd;
  logic [WW-1:0] pan_w, trig_w;
  logic          period_end;
  logic          done_q;

  assign period_end = (cnt == CNT_LAST);

  always_comb begin
    state_nx = state;
    dwell_nx = dwell;
    tgt_nx   = tgt;
    pan_cmd  = HOME_A;
    trig_cmd = REST_A;
    case (state)
      S_IDLE: begin
        if (i_kill_req && !i_abort) begin
          tgt_nx   = i_target_angle;
          dwell_nx = '0;
          state_nx = S_AIM;
        end
      end
      S_AIM: begin
        pan_cmd = tgt;
        if (i_abort) begin
          state_nx = S_RETURN;
          dwell_nx = '0;
        end else if (period_end) begin
          if (dwell == AIM_LAST) begin
            state_nx = S_FIRE;
            dwell_nx = '0;
          end else begin
            dwell_nx = dwell + 1'b1;
          end
        end
      end
      S_FIRE: begin
        pan_cmd  = tgt;
        trig_cmd = FIRE_A;
        if (i_abort) begin
          state_nx = S_RETURN;
          dwell_nx = '0;
        end else if (period_end) begin
          if (dwell == FIRE_LAST) begin
            state_nx = S_RETURN;
            dwell_nx = '0;
          end else begin
            dwell_nx = dwell + 1'b1;
          end
        end
      end
      S_RETURN: begin
        if (period_end) begin
          if (dwell == RET_LAST) begin
            state_nx = S_DONE;
            dwell_nx = '0;
          end else begin
            dwell_nx = dwell + 1'b1;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_25) begin
    if (i_rst) begin
      cnt        <= '0;
      state      <= S_IDLE;
      dwell      <= '0;
      tgt        <= '0;
      pan_w      <= pulse(HOME_A);
      trig_w     <= pulse(REST_A);
      o_pwm_pan  <= 1'b0;
      o_pwm_trig <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt   <= period_end ? '0 : cnt + 1'b1;
      state <= state_nx;
      dwell <= dwell_nx;
      tgt   <= tgt_nx;
      if (period_end) begin
        pan_w  <= pulse(pan_cmd);
        trig_w <= pulse(trig_cmd);
      end
      o_pwm_pan  <= (WW'(cnt) < pan_w);
      o_pwm_trig <= (WW'(cnt) < trig_w);
      done_q     <= (state_nx == S_DONE);
    end
  end

  assign o_busy  = (state != S_IDLE);
  assign o_done  = done_q;
  assign o_state = state;

endmodule
